// File: rtl/ecc_point_add_seq.sv
// ecc_point_add_seq: runs the 9-step affine point-add micro-program on the GFAU; `define ECC_PADD_INF_EN enables point-at-infinity handling
module ecc_point_add_seq #(
    parameter int SIZE = 33
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] x1,
    input  logic [SIZE-1:0] y1,
    input  logic [SIZE-1:0] x2,
    input  logic [SIZE-1:0] y2,
    input  logic [SIZE-1:0] prime,
    input  logic            in_inf_p,
    input  logic            in_inf_q,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [SIZE-1:0] x3,
    output logic [SIZE-1:0] y3,
    output logic            out_inf,
    output logic [1:0]      gfau_op,
    output logic [SIZE-1:0] gfau_in_0,
    output logic [SIZE-1:0] gfau_in_1,
    output logic            gfau_go,
    input  logic [SIZE-1:0] gfau_result,
    input  logic            gfau_done,
    output logic [3:0]      step
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;
    state_t state;
    logic [SIZE-1:0] r [8];
    logic [SIZE-1:0] r_nxt [8];
    logic [SIZE-1:0] b_x, b_y;
    logic [10:0] ins_cur, ins_nxt;
    logic [3:0] step_nxt;
    logic done_q, cap, same_x, same_y, byp, b_err, b_inf, iss, fin, unused_in;

    // {op, srcA, srcB, dst}; r4=t0 r5=t1 r6=lam r7=t2
    function automatic logic [10:0] rom(input logic [3:0] s);
        case (s)
            4'd0:    rom = {2'd1, 3'd3, 3'd1, 3'd4};
            4'd1:    rom = {2'd1, 3'd2, 3'd0, 3'd5};
            4'd2:    rom = {2'd3, 3'd4, 3'd5, 3'd6};
            4'd3:    rom = {2'd2, 3'd6, 3'd6, 3'd7};
            4'd4:    rom = {2'd1, 3'd7, 3'd0, 3'd7};
            4'd5:    rom = {2'd1, 3'd7, 3'd2, 3'd4};
            4'd6:    rom = {2'd1, 3'd0, 3'd4, 3'd5};
            4'd7:    rom = {2'd2, 3'd6, 3'd5, 3'd5};
            default: rom = {2'd1, 3'd5, 3'd1, 3'd7};
        endcase
    endfunction

    assign cap       = state == WAIT && gfau_done && !done_q;
    assign step_nxt  = state == LOAD ? 4'd0 : step + 4'd1;
    assign ins_cur   = rom(step);
    assign ins_nxt   = rom(step_nxt);
    assign same_x    = x1 == x2;
    assign same_y    = y1 == y2;
    assign iss       = (state == LOAD && !byp) || (cap && step != 4'd8);
    assign fin       = (state == LOAD && byp) || (cap && step == 4'd8);
    assign unused_in = ^{prime, in_inf_p, in_inf_q, same_y, ins_cur[10:3]};

`ifdef ECC_PADD_INF_EN
    assign byp   = in_inf_p || in_inf_q || same_x;
    assign b_inf = (in_inf_p && in_inf_q) || (!in_inf_p && !in_inf_q && same_x && !same_y);
    assign b_err = !in_inf_p && !in_inf_q && same_x && same_y;
    assign b_x   = in_inf_p && !in_inf_q ? x2 : in_inf_q && !in_inf_p ? x1 : '0;
    assign b_y   = in_inf_p && !in_inf_q ? y2 : in_inf_q && !in_inf_p ? y1 : '0;
`else
    assign byp   = same_x;
    assign b_inf = 1'b0;
    assign b_err = same_x;
    assign b_x   = '0;
    assign b_y   = '0;
`endif

    // Next view of the scratch file, so a value written this cycle can feed the following issue
    always_comb begin
        r_nxt = r;
        if (state == LOAD) begin
            r_nxt[0] = x1;
            r_nxt[1] = y1;
            r_nxt[2] = x2;
            r_nxt[3] = y2;
        end
        if (cap) r_nxt[ins_cur[2:0]] = gfau_result;
    end

    // Sequencer FSM with registered GFAU controls and results
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            for (int i = 0; i < 8; i++) r[i] <= '0;
            done_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            out_inf   <= 1'b0;
            x3        <= '0;
            y3        <= '0;
            gfau_go   <= 1'b0;
            gfau_op   <= 2'd0;
            gfau_in_0 <= '0;
            gfau_in_1 <= '0;
            step      <= 4'd0;
        end else begin
            r      <= r_nxt;
            done_q <= gfau_done;
            done   <= 1'b0;
            if (iss) begin
                state     <= ISSUE;
                step      <= step_nxt;
                gfau_go   <= 1'b1;
                gfau_op   <= ins_nxt[10:9];
                gfau_in_0 <= r_nxt[ins_nxt[8:6]];
                gfau_in_1 <= r_nxt[ins_nxt[5:3]];
            end else if (fin) begin
                state   <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                err     <= state == LOAD && b_err;
                out_inf <= state == LOAD && b_inf;
                x3      <= state == LOAD ? b_x : r_nxt[4];
                y3      <= state == LOAD ? b_y : r_nxt[7];
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                    ISSUE: begin
                        state   <= WAIT;
                        gfau_go <= 1'b0;
                    end
                    DONE: state <= IDLE;
                    default: ;
                endcase
            end
        end
    end
endmodule
